// File: rtl/id_stage_pipe.sv
// RV32 decode stage: control decode, regfile, immediates, ID/EX register; optional WB bypass under ID_WB_BYPASS_EN.
// Latency: 1 cycle from IF accept to ex_valid; load-use costs one bubble, WB conflict stalls one cycle without bypass.
// Backpressure: if_ready drops on hazard or when the held ID/EX entry is not consumed; payload holds while stalled.
module id_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [8:0]      ex_ctrl
);
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    function automatic logic in_range(input logic [4:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    logic [4:0]      rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_d;
    logic [8:0]      ctrl_raw, ctrl_d;
    logic            op_legal, use_rs1, use_rs2, use_rd, illegal, rs1_used, rs2_used;
    logic [XLEN-1:0] rs1_data_d, rs2_data_d;
    logic            wb_fire, wb_hit1, wb_hit2, hazard_lu, hazard_wb, accept;
    logic            unused_funct3;

    logic [XLEN-1:0] rf_q [NREGS];

    logic            ex_valid_q;
    logic [XLEN-1:0] ex_pc_q, ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
    logic [4:0]      ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic [8:0]      ex_ctrl_q;

    assign rs1_idx       = if_instr[19:15];
    assign rs2_idx       = if_instr[24:20];
    assign rd_idx        = if_instr[11:7];
    assign unused_funct3 = ^if_instr[14:12];

    assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};

    // ctrl = {illegal, branch, memread, memwrite, memtoreg, alusrc, regwrite, aluop[1:0]}
    always_comb begin
        op_legal = 1'b1;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        ctrl_raw = 9'b0;
        imm_d    = '0;
        case (if_instr[6:0])
            7'b0110011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; ctrl_raw = 9'b0_0000_0110; end
            7'b0010011: begin use_rs1 = 1'b1; use_rd = 1'b1; ctrl_raw = 9'b0_0000_1111; imm_d = imm_i; end
            7'b0000011: begin use_rs1 = 1'b1; use_rd = 1'b1; ctrl_raw = 9'b0_0101_1100; imm_d = imm_i; end
            7'b0100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; ctrl_raw = 9'b0_0010_1000; imm_d = imm_s; end
            7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; ctrl_raw = 9'b0_1000_0001; imm_d = imm_b; end
            default:    op_legal = 1'b0;
        endcase
        illegal  = !op_legal || (use_rs1 && !in_range(rs1_idx)) ||
                   (use_rs2 && !in_range(rs2_idx)) || (use_rd && !in_range(rd_idx));
        ctrl_d   = illegal ? 9'b1_0000_0000 : ctrl_raw;
        rs1_used = use_rs1 && !illegal;
        rs2_used = use_rs2 && !illegal;
    end

    assign wb_fire = wb_we && (wb_rd != 5'd0) && in_range(wb_rd);
    assign wb_hit1 = wb_fire && rs1_used && (wb_rd == rs1_idx);
    assign wb_hit2 = wb_fire && rs2_used && (wb_rd == rs2_idx);

    always_comb begin
        rs1_data_d = (rs1_idx != 5'd0 && in_range(rs1_idx)) ? rf_q[rs1_idx[IW-1:0]] : '0;
        rs2_data_d = (rs2_idx != 5'd0 && in_range(rs2_idx)) ? rf_q[rs2_idx[IW-1:0]] : '0;
`ifdef ID_WB_BYPASS_EN
        if (wb_hit1) rs1_data_d = wb_data;
        if (wb_hit2) rs2_data_d = wb_data;
        hazard_wb = 1'b0;
`else
        hazard_wb = wb_hit1 || wb_hit2;
`endif
    end

    // Only a load sitting in ID/EX can't be forwarded by EX; stall one cycle behind it.
    assign hazard_lu = ex_valid_q && ex_ctrl_q[6] && (ex_rd_q != 5'd0) &&
                       ((rs1_used && rs1_idx == ex_rd_q) || (rs2_used && rs2_idx == ex_rd_q));
    assign if_ready  = !(hazard_lu || hazard_wb) && (!ex_valid_q || ex_ready);
    assign accept    = if_valid && if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_fire) begin
            rf_q[wb_rd[IW-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_ctrl_q     <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (!ex_valid_q || ex_ready) begin
            ex_valid_q <= accept;
            if (accept) begin
                ex_pc_q       <= if_pc;
                ex_rs1_data_q <= rs1_data_d;
                ex_rs2_data_q <= rs2_data_d;
                ex_imm_q      <= imm_d;
                ex_rs1_q      <= rs1_idx;
                ex_rs2_q      <= rs2_idx;
                ex_rd_q       <= rd_idx;
                ex_ctrl_q     <= ctrl_d;
            end
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rs1_data = ex_rs1_data_q;
    assign ex_rs2_data = ex_rs2_data_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_ctrl     = ex_ctrl_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic against a transaction-level model.
module tb_id_stage_pipe;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic        clk = 1'b0;
    logic        rst_n, flush, if_valid, wb_we, ex_ready;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_rd;

    logic        if_ready, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [8:0]  ex_ctrl;

    logic        r16_if_ready, r16_ex_valid;
    logic [31:0] r16_pc, r16_rs1_data, r16_rs2_data, r16_imm;
    logic [4:0]  r16_rs1, r16_rs2, r16_rd;
    logic [8:0]  r16_ctrl;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl));

    id_stage_pipe #(.XLEN(XLEN), .NREGS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .if_valid(if_valid), .if_ready(r16_if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(r16_ex_valid), .ex_ready(ex_ready), .ex_pc(r16_pc), .ex_rs1_data(r16_rs1_data),
        .ex_rs2_data(r16_rs2_data), .ex_imm(r16_imm), .ex_rs1(r16_rs1), .ex_rs2(r16_rs2),
        .ex_rd(r16_rd), .ex_ctrl(r16_ctrl));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] imm;
        logic        u1;
        logic        u2;
    } dec_t;

    function automatic dec_t dec(input logic [31:0] ins);
        dec_t d;
        logic ud, ok;
        int   v;
        d = '0; ud = 1'b0; ok = 1'b1;
        case (ins[6:0])
            7'h33: begin d.ctrl = 9'h006; d.u1 = 1; d.u2 = 1; ud = 1; end
            7'h13: begin d.ctrl = 9'h00F; d.u1 = 1; ud = 1; d.imm = 32'($signed(ins) >>> 20); end
            7'h03: begin d.ctrl = 9'h05C; d.u1 = 1; ud = 1; d.imm = 32'($signed(ins) >>> 20); end
            7'h23: begin
                d.ctrl = 9'h028; d.u1 = 1; d.u2 = 1;
                v = (int'($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
                d.imm = 32'(v);
            end
            7'h63: begin
                d.ctrl = 9'h081; d.u1 = 1; d.u2 = 1;
                v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                d.imm = 32'(v);
            end
            default: ok = 1'b0;
        endcase
        if ((d.u1 && int'(ins[19:15]) >= NREGS) || (d.u2 && int'(ins[24:20]) >= NREGS) ||
            (ud && int'(ins[11:7]) >= NREGS)) ok = 1'b0;
        if (!ok) begin d.ctrl = 9'h100; d.u1 = 0; d.u2 = 0; end
        return d;
    endfunction

    logic [31:0] m_rf [32];
    logic        m_vld, m_u1, m_u2;
    logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [8:0]  m_ctrl;

    function automatic logic [31:0] rv(input logic [4:0] idx);
        if (idx == 0 || int'(idx) >= NREGS) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_rd == idx) return wb_data;
`endif
        return m_rf[idx];
    endfunction

    function automatic logic exp_ready();
        dec_t d;
        logic [4:0] a, b;
        logic hz;
        d = dec(if_instr);
        a = if_instr[19:15];
        b = if_instr[24:20];
        hz = m_vld && m_ctrl[6] && m_rd != 0 && ((d.u1 && a == m_rd) || (d.u2 && b == m_rd));
`ifndef ID_WB_BYPASS_EN
        hz = hz || (wb_we && wb_rd != 0 && ((d.u1 && a == wb_rd) || (d.u2 && b == wb_rd)));
`endif
        return !hz && (!m_vld || ex_ready);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_vld = 0; m_u1 = 0; m_u2 = 0;
        m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
    endtask

    task automatic model_step();
        dec_t d;
        logic acc;
        if (!rst_n) begin model_reset(); return; end
        d = dec(if_instr);
        acc = if_valid && exp_ready();
        if (flush) m_vld = 0;
        else if (!m_vld || ex_ready) begin
            m_vld = acc;
            if (acc) begin
                m_pc = if_pc; m_imm = d.imm; m_ctrl = d.ctrl; m_u1 = d.u1; m_u2 = d.u2;
                m_rs1 = if_instr[19:15]; m_rs2 = if_instr[24:20]; m_rd = if_instr[11:7];
                m_rs1d = rv(m_rs1); m_rs2d = rv(m_rs2);
            end
        end
        if (wb_we && wb_rd != 0 && int'(wb_rd) < NREGS) m_rf[wb_rd] = wb_data;
    endtask

    task automatic compare();
        chk("if_ready", {31'b0, if_ready}, {31'b0, exp_ready()});
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_vld});
        if (m_vld) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_ctrl", {23'b0, ex_ctrl}, {23'b0, m_ctrl});
            chk("ex_rs1", {27'b0, ex_rs1}, {27'b0, m_rs1});
            chk("ex_rs2", {27'b0, ex_rs2}, {27'b0, m_rs2});
            chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
            if (m_u1) chk("ex_rs1_data", ex_rs1_data, m_rs1d);
            if (m_u2) chk("ex_rs2_data", ex_rs2_data, m_rs2d);
        end
    endtask

    // Inputs change at negedge; outputs are compared 1ns later, model advances at posedge.
    task automatic tick();
        #1;
        compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v; if_instr = ins; if_pc = pc;
    endtask

    initial begin
        dec_t d;
        rst_n = 0; flush = 0; if_valid = 0; if_instr = 0; if_pc = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; ex_ready = 1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_ex_pc", ex_pc, 32'h0);
        chk("rst_ex_imm", ex_imm, 32'h0);
        chk("rst_ex_ctrl", {23'b0, ex_ctrl}, 32'h0);
        chk("rst_ex_rd", {27'b0, ex_rd}, 32'h0);
        chk("rst_ex_rs1_data", ex_rs1_data, 32'h0);
        chk("rst_if_ready", {31'b0, if_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1;

        d = dec(32'hFFB00093);
        chk("model_addi_imm", d.imm, 32'hFFFFFFFB);
        d = dec(32'h00208463);
        chk("model_beq_imm", d.imm, 32'h00000008);

        drive(1, 32'h00208A33, 32'h100);
        tick();
        chk("r16_illegal_valid", {31'b0, r16_ex_valid}, 32'h1);
        chk("r16_illegal_ctrl", {23'b0, r16_ctrl}, 32'h100);
        chk("r32_add_ctrl", {23'b0, ex_ctrl}, 32'h006);

        drive(1, 32'hFFB00093, 32'h104);
        tick();
        chk("addi_valid", {31'b0, ex_valid}, 32'h1);
        chk("addi_imm", ex_imm, 32'hFFFFFFFB);
        chk("addi_ctrl", {23'b0, ex_ctrl}, 32'h00F);
        chk("addi_rd", {27'b0, ex_rd}, 32'h1);

        drive(1, 32'h0000A103, 32'h108);
        tick();
        drive(1, 32'h002101B3, 32'h10C);
        #1 chk("lu_stall_ready", {31'b0, if_ready}, 32'h0);
        tick();
        chk("lu_bubble", {31'b0, ex_valid}, 32'h0);
        chk("lu_release", {31'b0, if_ready}, 32'h1);
        tick();
        chk("lu_add_valid", {31'b0, ex_valid}, 32'h1);
        chk("lu_add_pc", ex_pc, 32'h10C);
        chk("lu_add_rd", {27'b0, ex_rd}, 32'h3);

        wb_we = 1; wb_rd = 5; wb_data = 32'h1234;
        drive(1, 32'h00028333, 32'h110);
`ifdef ID_WB_BYPASS_EN
        #1 chk("wb_bypass_ready", {31'b0, if_ready}, 32'h1);
        tick();
        wb_we = 0;
`else
        #1 chk("wb_stall_ready", {31'b0, if_ready}, 32'h0);
        tick();
        wb_we = 0;
        tick();
`endif
        chk("wb_rs1_data", ex_rs1_data, 32'h1234);
        chk("wb_pc", ex_pc, 32'h110);

        ex_ready = 0;
        drive(1, 32'h00700493, 32'h114);
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_if_ready", {31'b0, if_ready}, 32'h0);
            chk("hold_pc", ex_pc, 32'h110);
            chk("hold_rd", {27'b0, ex_rd}, 32'h6);
            tick();
        end
        ex_ready = 1;
        tick();
        chk("hold_next_pc", ex_pc, 32'h114);
        chk("hold_next_rd", {27'b0, ex_rd}, 32'h9);
        drive(0, 32'h00700493, 32'h114);
        tick();
        chk("hold_no_dup", {31'b0, ex_valid}, 32'h0);

        flush = 1;
        drive(1, 32'h00208463, 32'h118);
        #1 chk("flush_ready", {31'b0, if_ready}, 32'h1);
        tick();
        flush = 0;
        drive(0, 32'h0, 32'h0);
        chk("flush_drop", {31'b0, ex_valid}, 32'h0);
        tick();
        chk("flush_never", {31'b0, ex_valid}, 32'h0);

        wb_we = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
        tick();
        wb_we = 0;
        drive(1, 32'h000003B3, 32'h11C);
        tick();
        chk("x0_valid", {31'b0, ex_valid}, 32'h1);
        chk("x0_read", ex_rs1_data, 32'h0);
        chk("x0_read_r16", r16_rs1_data, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            case ($urandom_range(0, 5))
                0: ins[6:0] = 7'h33;
                1: ins[6:0] = 7'h13;
                2: ins[6:0] = 7'h03;
                3: ins[6:0] = 7'h23;
                4: ins[6:0] = 7'h63;
                default: ins[6:0] = 7'h7F;
            endcase
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 9) < 8, ins, $urandom);
            ex_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 11) == 0);
            wb_we    = ($urandom_range(0, 9) < 3);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            if (i == 1500) begin rst_n = 0; model_reset(); end
            if (i == 1502) rst_n = 1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
